// File: rtl/config_sequencer.sv
// Config command front end: single/burst write/read commands to the node
// configurator, read data returned through a 2-entry response FIFO.
module config_sequencer #(
  parameter int CDW   = 21,
  parameter int CAW   = 15,
  parameter int ATW   = 3,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CAW-1:0]   cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdat_valid,
  output logic             wdat_ready,
  input  logic [CDW-1:0]   wdat_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CDW-1:0]   rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             config_we,
  output logic [CAW-1:0]   config_waddr,
  output logic [CDW-1:0]   config_wdata,
  output logic             config_re,
  output logic [CAW-1:0]   config_raddr,
  input  logic [CDW-1:0]   config_rdata,
  input  logic             config_clear_done
);

  localparam int LW = CAW - ATW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CLR
  } state_t;

  state_t           state_q, state_d;
  logic [CAW-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             wr_fire;
  logic             rd_issue;
  logic             infl_q;
  logic             infl_last_q;

  logic [CDW:0]     mem [2];
  logic             rptr_q, wptr_q;
  logic [1:0]       fcnt_q;
  logic             push, pop;
  logic             rd_room;

  // Low field wraps; the type field pins a burst to its region.
  function automatic logic [CAW-1:0] addr_inc(input logic [CAW-1:0] a);
    return {a[CAW-1:LW], a[LW-1:0] + LW'(1)};
  endfunction

  assign push = infl_q;
  assign pop  = rsp_valid & rsp_ready;

  // A pop this cycle frees the slot the new read lands in two edges later.
  assign rd_room = ({1'b0, fcnt_q} + {2'b0, infl_q})
                 < (3'd2 + {2'b0, pop});

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    cmd_ready  = 1'b0;
    wdat_ready = 1'b0;
    wr_fire    = 1'b0;
    rd_issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_op[1] ? cmd_len : '0;
          state_d = cmd_op[0] ? S_RD : S_WR;
        end
      end
      S_WR: begin
        wdat_ready = 1'b1;
        if (wdat_valid) begin
          wr_fire = 1'b1;
          addr_d  = addr_inc(addr_q);
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            if (addr_q == '0 && wdat_data[1] && !config_clear_done)
              state_d = S_CLR;
            else
              state_d = S_IDLE;
          end
        end
      end
      S_RD: begin
        if (rd_room) begin
          rd_issue = 1'b1;
          addr_d   = addr_inc(addr_q);
          cnt_d    = cnt_q - LEN_W'(1);
          if (cnt_q == '0)
            state_d = S_IDLE;
        end
      end
      S_CLR: begin
        if (config_clear_done)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      cmd_ready  = 1'b0;
      wdat_ready = 1'b0;
      wr_fire    = 1'b0;
      rd_issue   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      config_we    <= 1'b0;
      config_waddr <= '0;
      config_wdata <= '0;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      config_we   <= wr_fire;
      infl_q      <= rd_issue;
      infl_last_q <= rd_issue && (cnt_q == '0);
      if (wr_fire) begin
        config_waddr <= addr_q;
        config_wdata <= wdat_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      if (push) begin
        mem[wptr_q] <= {infl_last_q, config_rdata};
        wptr_q      <= ~wptr_q;
      end
      if (pop)
        rptr_q <= ~rptr_q;
      fcnt_q <= fcnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rsp_valid    = (fcnt_q != '0);
  assign rsp_data     = rsp_valid ? mem[rptr_q][CDW-1:0] : '0;
  assign rsp_last     = rsp_valid ? mem[rptr_q][CDW] : 1'b0;
  assign config_re    = rd_issue;
  assign config_raddr = addr_q;
  assign busy         = !rst && ((state_q != S_IDLE) || rsp_valid || infl_q);

endmodule

// File: tb/tb_config_sequencer.sv
// Directed bench for config_sequencer: writes, bursts, read
// backpressure, STATUS clear stall and reset mid-burst.
module tb_config_sequencer;

  localparam int CDW   = 21;
  localparam int CAW   = 15;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CAW-1:0]   cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             wdat_valid;
  logic             wdat_ready;
  logic [CDW-1:0]   wdat_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [CDW-1:0]   rsp_data;
  logic             rsp_last;
  logic             busy;
  logic             config_we;
  logic [CAW-1:0]   config_waddr;
  logic [CDW-1:0]   config_wdata;
  logic             config_re;
  logic [CAW-1:0]   config_raddr;
  logic [CDW-1:0]   config_rdata = '0;
  logic             config_clear_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [CAW-1:0] we_a [$];
  logic [CDW-1:0] we_d [$];
  logic [CAW-1:0] re_a [$];
  int             re_c [$];
  logic [CDW-1:0] rs_d [$];
  logic           rs_l [$];

  config_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_op            (cmd_op),
    .cmd_addr          (cmd_addr),
    .cmd_len           (cmd_len),
    .wdat_valid        (wdat_valid),
    .wdat_ready        (wdat_ready),
    .wdat_data         (wdat_data),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .rsp_last          (rsp_last),
    .busy              (busy),
    .config_we         (config_we),
    .config_waddr      (config_waddr),
    .config_wdata      (config_wdata),
    .config_re         (config_re),
    .config_raddr      (config_raddr),
    .config_rdata      (config_rdata),
    .config_clear_done (config_clear_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Configurator read model: data is a tag plus the address read.
  always @(posedge clk)
    config_rdata <= config_re ? {6'h2A, config_raddr} : '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (config_we) begin
        we_a.push_back(config_waddr);
        we_d.push_back(config_wdata);
      end
      if (config_re) begin
        re_a.push_back(config_raddr);
        re_c.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
        rs_d.push_back(rsp_data);
        rs_l.push_back(rsp_last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [CAW-1:0] a,
                          input logic [LEN_W-1:0] l);
    logic ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = l;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic send_beat(input logic [CDW-1:0] d);
    logic ok;
    ok         = 1'b0;
    wdat_valid = 1'b1;
    wdat_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = wdat_ready;
      @(posedge clk);
      #1;
    end
    wdat_valid = 1'b0;
    chk("beat_accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic clear_logs();
    we_a.delete();
    we_d.delete();
    re_a.delete();
    re_c.delete();
    rs_d.delete();
    rs_l.delete();
  endtask

  initial begin
    logic [CDW-1:0] bd [4];
    logic [CDW-1:0] e0;
    int hi;
    int nre;
    int nrs;

    bd[0] = 21'h0A001;
    bd[1] = 21'h1B002;
    bd[2] = 21'h0C003;
    bd[3] = 21'h1D004;

    rst               = 1'b1;
    cmd_valid         = 1'b0;
    cmd_op            = '0;
    cmd_addr          = '0;
    cmd_len           = '0;
    wdat_valid        = 1'b0;
    wdat_data         = '0;
    rsp_ready         = 1'b0;
    config_clear_done = 1'b0;

    step(2);
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_we", {31'b0, config_we}, 32'd0);
    chk("rst_re", {31'b0, config_re}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Single write; len is ignored for op 00
    clear_logs();
    send_cmd(2'b00, 15'h0004, 8'h55);
    send_beat(21'h00ABC);
    chk("sw_we", {31'b0, config_we}, 32'd1);
    chk("sw_waddr", 32'(config_waddr), 32'h0004);
    chk("sw_wdata", 32'(config_wdata), 32'h00ABC);
    chk("sw_idle", {31'b0, cmd_ready}, 32'd1);
    chk("sw_no_wready", {31'b0, wdat_ready}, 32'd0);
    step(2);
    chk("sw_we_count", 32'(we_a.size()), 32'd1);

    // Burst write wrapping inside its type region, with a bubble
    clear_logs();
    send_cmd(2'b10, 15'h2FFE, 8'd3);
    send_beat(bd[0]);
    send_beat(bd[1]);
    step(1);
    send_beat(bd[2]);
    send_beat(bd[3]);
    step(2);
    chk("bw_count", 32'(we_a.size()), 32'd4);
    chk("bw_a0", 32'(we_a[0]), 32'h2FFE);
    chk("bw_a1", 32'(we_a[1]), 32'h2FFF);
    chk("bw_a2", 32'(we_a[2]), 32'h2000);
    chk("bw_a3", 32'(we_a[3]), 32'h2001);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bw_d%0d", i), 32'(we_d[i]), 32'(bd[i]));
    chk("bw_idle", {31'b0, cmd_ready}, 32'd1);

    // Burst read, consumer always ready
    clear_logs();
    rsp_ready = 1'b1;
    send_cmd(2'b11, 15'h4000, 8'd7);
    step(16);
    chk("br_re_count", 32'(re_a.size()), 32'd8);
    chk("br_b2b", 32'(re_c[7] - re_c[0]), 32'd7);
    chk("br_rsp_count", 32'(rs_d.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("br_ra%0d", i), 32'(re_a[i]), 32'h4000 + 32'(i));
      chk($sformatf("br_rd%0d", i), 32'(rs_d[i]),
          32'h150000 + 32'h4000 + 32'(i));
      chk($sformatf("br_last%0d", i), {31'b0, rs_l[i]},
          (i == 7) ? 32'd1 : 32'd0);
    end
    chk("br_busy", {31'b0, busy}, 32'd0);

    // Same read under backpressure
    clear_logs();
    rsp_ready = 1'b0;
    send_cmd(2'b11, 15'h4000, 8'd7);
    step(8);
    e0 = {6'h2A, 15'h4000};
    chk("bp_re_count", 32'(re_a.size()), 32'd2);
    chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp_data", 32'(rsp_data), 32'(e0));
    chk("bp_last", {31'b0, rsp_last}, 32'd0);
    chk("bp_busy", {31'b0, busy}, 32'd1);
    step(3);
    chk("bp_hold_data", 32'(rsp_data), 32'(e0));
    chk("bp_hold_re", 32'(re_a.size()), 32'd2);
    rsp_ready = 1'b1;
    step(16);
    chk("bp_re_total", 32'(re_a.size()), 32'd8);
    chk("bp_rsp_total", 32'(rs_d.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_ra%0d", i), 32'(re_a[i]), 32'h4000 + 32'(i));
      chk($sformatf("bp_rd%0d", i), 32'(rs_d[i]),
          32'h150000 + 32'h4000 + 32'(i));
    end
    chk("bp_last6", {31'b0, rs_l[6]}, 32'd0);
    chk("bp_last7", {31'b0, rs_l[7]}, 32'd1);

    // STATUS write with clear bit: stall until clear_done
    clear_logs();
    send_cmd(2'b00, 15'h0000, 8'd0);
    send_beat(21'h000002);
    chk("clr_we", {31'b0, config_we}, 32'd1);
    chk("clr_waddr", 32'(config_waddr), 32'h0);
    chk("clr_wdata", 32'(config_wdata), 32'h2);
    chk("clr_stall", {31'b0, cmd_ready}, 32'd0);
    hi = 0;
    repeat (4) begin
      step(1);
      hi += int'(cmd_ready);
    end
    chk("clr_hold", 32'(hi), 32'd0);
    chk("clr_busy", {31'b0, busy}, 32'd1);
    config_clear_done = 1'b1;
    #1;
    chk("clr_pulse_cycle", {31'b0, cmd_ready}, 32'd0);
    step(1);
    config_clear_done = 1'b0;
    #1;
    chk("clr_release", {31'b0, cmd_ready}, 32'd1);
    chk("clr_idle_busy", {31'b0, busy}, 32'd0);

    // clear_done coincides with the STATUS write cycle
    send_cmd(2'b00, 15'h0000, 8'd0);
    send_beat(21'h000002);
    config_clear_done = 1'b1;
    step(1);
    config_clear_done = 1'b0;
    #1;
    chk("clr_same_we", {31'b0, cmd_ready}, 32'd1);

    // clear_done coincides with the beat acceptance
    send_cmd(2'b00, 15'h0000, 8'd0);
    config_clear_done = 1'b1;
    send_beat(21'h000002);
    config_clear_done = 1'b0;
    #1;
    chk("clr_same_beat", {31'b0, cmd_ready}, 32'd1);

    // STATUS write without the clear bit does not stall
    send_cmd(2'b00, 15'h0000, 8'd0);
    send_beat(21'h000001);
    chk("status_noclr", {31'b0, cmd_ready}, 32'd1);

    // Reset in the middle of a burst read
    clear_logs();
    rsp_ready = 1'b1;
    send_cmd(2'b11, 15'h4000, 8'd7);
    for (int i = 0; i < 20 && re_a.size() < 3; i++)
      step(1);
    chk("mid_reach3", 32'(re_a.size()), 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_re_gated", {31'b0, config_re}, 32'd0);
    step(1);
    chk("mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_re", {31'b0, config_re}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    nre = re_a.size();
    nrs = rs_d.size();
    rst = 1'b0;
    #1;
    chk("mid_ready_after", {31'b0, cmd_ready}, 32'd1);
    step(6);
    chk("mid_no_more_re", 32'(re_a.size()), 32'(nre));
    chk("mid_no_more_rsp", 32'(rs_d.size()), 32'(nrs));
    chk("mid_fifo_empty", {31'b0, rsp_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
